// File: rtl/spike_aer_encoder.sv
// Spike output stage: edge-detects neuron fire flags, arbitrates them round-robin
// and queues {address, timestamp} events in an FWFT FIFO drained by valid/ready.
module spike_aer_encoder #(
    parameter int p_neurons = 8,
    parameter int p_addr_w  = 3,
    parameter int p_ts_w    = 16,
    parameter int p_depth   = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [p_neurons:1]  i_spike,
    input  logic                i_aer_ready,
    input  logic                i_clr_ovf,
    output logic                o_aer_valid,
    output logic [p_addr_w-1:0] o_aer_addr,
    output logic [p_ts_w-1:0]   o_aer_ts,
    output logic [p_neurons:1]  o_pending,
    output logic                o_overflow,
    output logic [7:0]          o_drop_cnt
);
    localparam int PTR_W  = $clog2(p_depth);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = p_addr_w + p_ts_w;
    localparam int DROP_W = $clog2(p_neurons + 1);
    localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(p_depth);
    localparam logic [p_addr_w-1:0] LAST_IDX = p_addr_w'(p_neurons - 1);

    logic [p_neurons:1]  prev;
    logic [p_neurons:1]  pending;
    logic [p_addr_w-1:0] rr;          // zero-based: holds rr-1, so reset 0 means neuron 1
    logic [p_ts_w-1:0]   ts_cnt;
    logic                overflow;
    logic [7:0]          drop_cnt;
    logic [WORD_W-1:0]   mem [p_depth];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_cnt;

    logic [p_neurons:1]  rise;
    logic [p_neurons:1]  grant;
    logic [p_neurons:1]  drop;
    logic                gnt_valid;
    logic [p_addr_w-1:0] gnt_addr;
    logic [DROP_W-1:0]   drop_n;
    logic [31:0]         cnt_sum;
    logic                rd_en;
    int unsigned         idx;

    assign rise  = i_spike & ~prev;
    assign drop  = rise & pending & ~grant;
    assign rd_en = o_aer_valid & i_aer_ready;

    always_comb begin
        grant     = '0;
        gnt_valid = 1'b0;
        gnt_addr  = '0;
        idx       = 0;
        // Registered count only: a read this cycle does not open a slot.
        if (fifo_cnt != FULL_CNT) begin
            for (int unsigned i = 0; i < p_neurons; i++) begin
                idx = (32'(rr) + i) % p_neurons;
                if (!gnt_valid && pending[idx+1]) begin
                    gnt_valid      = 1'b1;
                    grant[idx+1]   = 1'b1;
                    gnt_addr       = p_addr_w'(idx);
                end
            end
        end
    end

    always_comb begin
        drop_n = '0;
        for (int unsigned i = 1; i <= p_neurons; i++) begin
            drop_n = drop_n + DROP_W'(drop[i]);
        end
        cnt_sum = (i_clr_ovf ? 32'd0 : 32'(drop_cnt)) + 32'(drop_n);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev     <= '0;
            pending  <= '0;
            rr       <= '0;
            ts_cnt   <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            prev     <= i_spike;
            pending  <= (pending & ~grant) | rise;
            ts_cnt   <= ts_cnt + 1'b1;
            overflow <= (overflow & ~i_clr_ovf) | (|drop);
            drop_cnt <= (cnt_sum > 32'd255) ? 8'hFF : cnt_sum[7:0];
            if (gnt_valid) begin
                rr <= (gnt_addr == LAST_IDX) ? '0 : gnt_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < p_depth; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (gnt_valid) begin
                mem[wr_ptr] <= {gnt_addr, ts_cnt};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({gnt_valid, rd_en})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign o_aer_valid = (fifo_cnt != '0);
    assign {o_aer_addr, o_aer_ts} = mem[rd_ptr];
    assign o_pending   = pending;
    assign o_overflow  = overflow;
    assign o_drop_cnt  = drop_cnt;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Scoreboard bench for spike_aer_encoder: expected AER words are queued as spikes
// are driven and compared as the encoder hands them over.
module tb_spike_aer_encoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:1]  spike;
    logic        aer_ready;
    logic        clr_ovf;
    logic        aer_valid;
    logic [2:0]  aer_addr;
    logic [15:0] aer_ts;
    logic [8:1]  pending;
    logic        overflow;
    logic [7:0]  drop_cnt;

    logic [15:0] tbc;
    logic [18:0] sb [$];
    logic [18:0] exp_word;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    spike_aer_encoder #(
        .p_neurons(8),
        .p_addr_w (3),
        .p_ts_w   (16),
        .p_depth  (8)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_spike    (spike),
        .i_aer_ready(aer_ready),
        .i_clr_ovf  (clr_ovf),
        .o_aer_valid(aer_valid),
        .o_aer_addr (aer_addr),
        .o_aer_ts   (aer_ts),
        .o_pending  (pending),
        .o_overflow (overflow),
        .o_drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference timestamp: counts clocks since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tbc <= '0;
        else        tbc <= tbc + 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && aer_valid && aer_ready) begin
            if (sb.size() == 0) begin
                check("sb_underrun", 32'(sb.size()), 1);
            end else begin
                exp_word = sb.pop_front();
                check("aer_word", {13'd0, aer_addr, aer_ts}, {13'd0, exp_word});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int n, input int dt);
        sb.push_back({3'(n - 1), 16'(tbc + 16'(dt))});
    endtask

    task automatic wait_ts(input logic [15:0] target);
        for (int i = 0; i < 300; i++) begin
            if (tbc == target) break;
            tick();
        end
        if (tbc != target) check("sync_ts", 32'(tbc), 32'(target));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 80; i++) begin
            if (sb.size() == 0 && !aer_valid) break;
            tick();
        end
        check({tag, "_drain"}, 32'(sb.size()), 0);
        check({tag, "_idle"}, 32'(aer_valid), 0);
    endtask

    task automatic pulse(input int n);
        spike[n] = 1'b1;
        push(n, 1);
        tick();
        spike[n] = 1'b0;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        spike     = '0;
        aer_ready = 1'b1;
        clr_ovf   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(aer_valid), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        check("rst_head", {13'd0, aer_addr, aer_ts}, 0);
        #3 rst_n = 1'b1;
        tick();

        // Single spike on neuron 3 sampled while counter reads 20.
        wait_ts(16'd20);
        spike[3] = 1'b1;
        push(3, 1);
        tick();
        spike[3] = 1'b0;
        check("single_pending", 32'(pending), 32'h04);
        check("single_valid_pre", 32'(aer_valid), 0);
        tick();
        check("single_valid", 32'(aer_valid), 1);
        check("single_pend_clr", 32'(pending), 0);
        tick();
        check("single_valid_once", 32'(aer_valid), 0);
        drain("single");

        // Neuron 8 returns rr to 1, then all eight together.
        pulse(8);
        drain("rr_home");
        spike = '1;
        for (int n = 1; n <= 8; n++) push(n, n);
        tick();
        spike = '0;
        drain("all8");
        spike[1] = 1'b1; spike[8] = 1'b1;
        push(1, 1); push(8, 2);
        tick();
        spike = '0;
        drain("rr_after_all8");

        // Round-robin from rr=6.
        pulse(5);
        drain("rr5");
        spike[2] = 1'b1; spike[7] = 1'b1;
        push(7, 1); push(2, 2);
        tick();
        spike = '0;
        drain("rr_27");
        pulse(5);
        drain("rr5b");
        spike[2] = 1'b1; spike[5] = 1'b1; spike[7] = 1'b1;
        push(7, 1); push(2, 2); push(5, 3);
        tick();
        spike = '0;
        drain("rr_257");

        // Backpressure: fill, then pend and drop on neuron 1.
        aer_ready = 1'b0;
        pulse(2); pulse(3); pulse(4); pulse(5);
        pulse(6); pulse(7); pulse(8); pulse(3);
        check("full_valid", 32'(aer_valid), 1);
        check("full_head", {13'd0, aer_addr, aer_ts}, {13'd0, sb[0]});
        spike[1] = 1'b1;
        tick();
        check("full_pend1", 32'(pending), 32'h01);
        spike[1] = 1'b0;
        tick();
        check("full_head_hold", {13'd0, aer_addr, aer_ts}, {13'd0, sb[0]});
        spike[1] = 1'b1;
        tick();
        spike[1] = 1'b0;
        check("drop_ovf", 32'(overflow), 1);
        check("drop_cnt", 32'(drop_cnt), 1);
        check("drop_pend_hold", 32'(pending), 32'h01);
        tick();
        check("full_head_stall", {13'd0, aer_addr, aer_ts}, {13'd0, sb[0]});
        check("full_sb_size", 32'(sb.size()), 8);
        aer_ready = 1'b1;
        push(1, 1);
        drain("backpressure");
        check("ovf_sticky", 32'(overflow), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_ovf", 32'(overflow), 0);
        check("clr_cnt", 32'(drop_cnt), 0);

        // Held level yields one event.
        spike[4] = 1'b1;
        push(4, 1);
        repeat (50) tick();
        spike[4] = 1'b0;
        drain("held");

        // Reset in the middle of a backlog.
        aer_ready = 1'b0;
        spike[5:1] = '1;
        tick();
        spike = '0;
        repeat (6) tick();
        spike[6] = 1'b1; spike[7] = 1'b1;
        tick();
        spike = '0;
        check("mid_pending", 32'(pending), 32'h60);
        check("mid_valid", 32'(aer_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(aer_valid), 0);
        check("arst_pending", 32'(pending), 0);
        check("arst_head", {13'd0, aer_addr, aer_ts}, 0);
        #3 rst_n = 1'b1;
        aer_ready = 1'b1;
        tick();
        wait_ts(16'd3);
        check("post_rst_quiet", 32'(aer_valid), 0);
        spike[8] = 1'b1;
        push(8, 1);
        tick();
        spike[8] = 1'b0;
        drain("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
